multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles per memory access, legal range 0..15.
REQ-002 SHALL have ports `clk` (in, 1): single clock, all state on rising edge.
REQ-003 SHALL have `reset` (in, 1): asynchronous, active-low.
REQ-004 SHALL have `opcode` (in, 7): bits [6:0] of the instruction register.
REQ-005 SHALL have `bcond` (in, 1): branch-taken flag from the ALU.
REQ-006 SHALL have `halt_req` (in, 1): datapath flag, x17 == 10.
REQ-007 SHALL have single-bit outputs: mem_read, mem_write, i_or_d, ir_write, mem_to_reg, reg_write, pc_to_reg, pc_write, alu_src_a, is_ecall, illegal_inst, halted.
REQ-008 SHALL have 2-bit outputs: alu_src_b (00 reg, 01 const 4, 10 imm), alu_op (00 add, 01 branch compare, 10 funct-decoded), pc_source (00 PC+4, 01 ALU target, 10 JALR target).

Function
REQ-009 SHALL implement states IF, ID, EX, MEM, WB, HALT; all outputs are decoded from state, opcode, bcond and wait counter; any output not listed for a state is 0.
REQ-010 IF: mem_read=1, i_or_d=0; wait counter counts 0..MEM_WAIT; on the cycle the count equals MEM_WAIT: ir_write=1, next state ID.
REQ-011 ID: alu_src_a=0, alu_src_b=01, alu_op=00 (PC+4).
REQ-012 ID next state: EX for LOAD, STORE, ARITHMETIC, ARITHMETIC_IMM, BRANCH, JAL, JALR; ECALL handled per REQ-023; otherwise illegal_inst=1 for one cycle, pc_write=1, pc_source=00, next state IF.
REQ-013 EX, ARITHMETIC: alu_src_a=1, alu_src_b=00, alu_op=10; next state WB.
REQ-014 EX, ARITHMETIC_IMM: alu_src_a=1, alu_src_b=10, alu_op=10; next state WB.
REQ-015 EX, LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM.
REQ-016 EX, BRANCH: alu_op=01, pc_write=1, pc_source=01 if bcond else 00; next state IF (3-cycle branch at MEM_WAIT=0).
REQ-017 EX, JAL: alu_src_a=0, alu_src_b=10, alu_op=00; next state WB.
REQ-018 EX, JALR: alu_src_a=1, alu_src_b=10, alu_op=00; next state WB.
REQ-019 MEM: i_or_d=1; mem_read=1 for LOAD or mem_write=1 for STORE, held for MEM_WAIT+1 cycles.
REQ-020 MEM, final cycle: LOAD goes to WB; STORE asserts pc_write=1, pc_source=00 and goes to IF.
REQ-021 WB: reg_write=1, pc_write=1, next state IF; mem_to_reg=1 for LOAD; pc_to_reg=1 for JAL/JALR.
REQ-022 WB pc_source: 01 for JAL, 10 for JALR, 00 otherwise.
REQ-023 ECALL in ID: is_ecall=1 for one cycle, then as in REQ-031/REQ-032.
REQ-024 Wait counter SHALL clear on every state transition; counter width is clog2(MEM_WAIT+1), minimum 1 bit.
REQ-025 With MEM_WAIT=0 the counter SHALL never be nonzero and each memory state SHALL last exactly 1 cycle.
REQ-026 mem_read and mem_write SHALL never be asserted in the same cycle; reg_write and pc_write SHALL each be asserted at most once per instruction.
REQ-027 Opcode changes outside IF/ID SHALL NOT alter the committed path; the IR is stable after ir_write.

Reset
REQ-028 reset low SHALL immediately force state IF, counter 0, halted=0, independent of clk.
REQ-029 During reset all outputs SHALL be 0 except mem_read=1 (IF decode); no pc_write or reg_write is emitted.
REQ-030 Reset asserted mid-instruction SHALL abandon the instruction with no further register or PC write; fetch restarts on the first rising edge after release.

Configuration
REQ-031 With `CTRL_ECALL_HALT_EN` defined, ECALL with halt_req=1 SHALL enter HALT: halted=1, all other outputs 0, exit only by reset; ECALL with halt_req=0 SHALL assert pc_write=1, pc_source=00 and go to IF.
REQ-032 Without `CTRL_ECALL_HALT_EN`, HALT is unreachable, halted is tied 0, and every ECALL behaves as halt_req=0.

Verification
REQ-033 MEM_WAIT=0, ADD (0110011): 4 cycles IF,ID,EX,WB; WB has reg_write=1, pc_write=1, pc_source=00.
REQ-034 MEM_WAIT=2, LW (0000011): IF 3 cycles, MEM 3 cycles with i_or_d=1 and mem_read=1, WB has mem_to_reg=1; 9 cycles total.
REQ-035 BEQ (1100011) with bcond=1 then bcond=0: EX has pc_source=01 then 00, pc_write=1, reg_write=0 in both.
REQ-036 With macro defined, ECALL (1110011) with halt_req=1: is_ecall pulse, halted=1 stays set for 20 cycles; undefined: returns to IF.
REQ-037 Reset pulled low during MEM of SW: mem_write drops asynchronously, state=IF, no pc_write; opcode 0000000 afterwards gives an illegal_inst pulse.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Purpose:
//    Control FSM for a multi-cycle RV32I-style datapath. It sequences
//    IF -> ID -> EX -> (MEM) -> (WB) per instruction. Every memory state
//    (IF, MEM) is stretched by MEM_WAIT extra wait cycles. All control
//    outputs are decoded from the state, the latched opcode, bcond and the
//    wait counter.
//
// Parameters:
//    MEM_WAIT  : extra wait cycles per memory access (0..15)
//
// Ports:
//    clk          in   rising-edge clock
//    reset        in   asynchronous, active-low reset
//    opcode[6:0]  in   instruction register bits [6:0]
//    bcond        in   branch-taken flag from the ALU
//    halt_req     in   datapath flag (x17 == 10), used by ECALL
//    mem_read, mem_write, i_or_d, ir_write, mem_to_reg, reg_write,
//    pc_to_reg, pc_write, alu_src_a, is_ecall, illegal_inst, halted
//                 out  single-bit control strobes
//    alu_src_b[1:0]  out  00 reg, 01 const 4, 10 imm
//    alu_op[1:0]     out  00 add, 01 branch compare, 10 funct-decoded
//    pc_source[1:0]  out  00 PC+4, 01 ALU target, 10 JALR target
//
// Configuration macro:
//    CTRL_ECALL_HALT_EN : when defined, ECALL with halt_req=1 enters a
//                         sticky HALT state (left only through reset).
// ---------------------------------------------------------------------------
module multi_cycle_control_unit #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       bcond,
   input  logic       halt_req,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       pc_to_reg,
   output logic       pc_write,
   output logic       alu_src_a,
   output logic       is_ecall,
   output logic       illegal_inst,
   output logic       halted,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source
);

   localparam int unsigned    CW      = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);
   localparam logic [CW-1:0]  LP_WAIT = CW'(MEM_WAIT);

   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   typedef enum logic [2:0] {
      S_IF,
      S_ID,
      S_EX,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [6:0]    r_op;      // opcode captured on leaving ID; EX/MEM/WB ignore the live input

   logic w_last;
   logic w_legal;
   logic w_ecall;
   logic w_halt_go;

   assign w_last  = (r_cnt == LP_WAIT);
   assign w_ecall = (opcode == OP_ECALL);
   assign w_legal = (opcode == OP_LOAD)   || (opcode == OP_STORE)     ||
                    (opcode == OP_ARITH)  || (opcode == OP_ARITH_IMM) ||
                    (opcode == OP_BRANCH) || (opcode == OP_JAL)       ||
                    (opcode == OP_JALR);

`ifdef CTRL_ECALL_HALT_EN
   assign w_halt_go = halt_req;
`else
   // Without the halt feature every ECALL behaves as halt_req = 0.
   logic w_unused_halt_req;
   assign w_unused_halt_req = halt_req;
   assign w_halt_go         = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State, wait counter and latched opcode
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IF;
         r_cnt   <= '0;
         r_op    <= '0;
      end else begin
         case (r_state)
            S_IF: begin
               if (w_last) begin
                  r_state <= S_ID;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ID: begin
               r_op  <= opcode;
               r_cnt <= '0;
               if (w_legal)
                  r_state <= S_EX;
               else if (w_ecall && w_halt_go)
                  r_state <= S_HALT;
               else
                  r_state <= S_IF;
            end
            S_EX: begin
               r_cnt <= '0;
               case (r_op)
                  OP_LOAD, OP_STORE: r_state <= S_MEM;
                  OP_BRANCH:         r_state <= S_IF;
                  default:           r_state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (w_last) begin
                  r_state <= (r_op == OP_LOAD) ? S_WB : S_IF;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_WB: begin
               r_state <= S_IF;
               r_cnt   <= '0;
            end
            S_HALT: begin
               r_state <= S_HALT;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= S_IF;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      ir_write     = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      pc_to_reg    = 1'b0;
      pc_write     = 1'b0;
      alu_src_a    = 1'b0;
      is_ecall     = 1'b0;
      illegal_inst = 1'b0;
      halted       = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      pc_source    = 2'b00;

      case (r_state)
         S_IF: begin
            mem_read = 1'b1;
            // Reset holds the IF state; the IR load strobe is suppressed
            // so that only the fetch read is visible while reset is low.
            ir_write = w_last && reset;
         end
         S_ID: begin
            alu_src_b = 2'b01;
            if (!w_legal) begin
               if (w_ecall) begin
                  is_ecall = 1'b1;
                  pc_write = !w_halt_go;
               end else begin
                  illegal_inst = 1'b1;
                  pc_write     = 1'b1;
               end
            end
         end
         S_EX: begin
            case (r_op)
               OP_ARITH: begin
                  alu_src_a = 1'b1;
                  alu_op    = 2'b10;
               end
               OP_ARITH_IMM: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
                  alu_op    = 2'b10;
               end
               OP_LOAD, OP_STORE, OP_JALR: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
               end
               OP_BRANCH: begin
                  alu_op    = 2'b01;
                  pc_write  = 1'b1;
                  pc_source = bcond ? 2'b01 : 2'b00;
               end
               OP_JAL: begin
                  alu_src_b = 2'b10;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (r_op == OP_STORE) begin
               mem_write = 1'b1;
               pc_write  = w_last;
            end else begin
               mem_read = 1'b1;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            mem_to_reg = (r_op == OP_LOAD);
            pc_to_reg  = (r_op == OP_JAL) || (r_op == OP_JALR);
            if (r_op == OP_JAL)
               pc_source = 2'b01;
            else if (r_op == OP_JALR)
               pc_source = 2'b10;
         end
         S_HALT: begin
`ifdef CTRL_ECALL_HALT_EN
            halted = 1'b1;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

   localparam logic [17:0] MR  = 18'h20000;
   localparam logic [17:0] MW  = 18'h10000;
   localparam logic [17:0] IOD = 18'h08000;
   localparam logic [17:0] IRW = 18'h04000;
   localparam logic [17:0] M2R = 18'h02000;
   localparam logic [17:0] RW  = 18'h01000;
   localparam logic [17:0] P2R = 18'h00800;
   localparam logic [17:0] PW  = 18'h00400;
   localparam logic [17:0] ASA = 18'h00200;
   localparam logic [17:0] EC  = 18'h00100;
   localparam logic [17:0] ILL = 18'h00080;
   localparam logic [17:0] HLT = 18'h00040;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] ARITH = 7'b0110011;
   localparam logic [6:0] ARIMM = 7'b0010011;
   localparam logic [6:0] BRAN  = 7'b1100011;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] JALR  = 7'b1100111;
   localparam logic [6:0] ECALL = 7'b1110011;

`ifdef CTRL_ECALL_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opc;
   logic        bc;
   logic        hr;
   logic [17:0] obs0;
   logic [17:0] obs1;

   int          checks = 0;
   int          errors = 0;
   logic [17:0] expq[$];

   always #5 clk = ~clk;

   multi_cycle_control_unit #(.MEM_WAIT(0)) u0 (
      .clk(clk), .reset(reset), .opcode(opc), .bcond(bc), .halt_req(hr),
      .mem_read(obs0[17]), .mem_write(obs0[16]), .i_or_d(obs0[15]),
      .ir_write(obs0[14]), .mem_to_reg(obs0[13]), .reg_write(obs0[12]),
      .pc_to_reg(obs0[11]), .pc_write(obs0[10]), .alu_src_a(obs0[9]),
      .is_ecall(obs0[8]), .illegal_inst(obs0[7]), .halted(obs0[6]),
      .alu_src_b(obs0[5:4]), .alu_op(obs0[3:2]), .pc_source(obs0[1:0])
   );

   multi_cycle_control_unit #(.MEM_WAIT(2)) u1 (
      .clk(clk), .reset(reset), .opcode(opc), .bcond(bc), .halt_req(hr),
      .mem_read(obs1[17]), .mem_write(obs1[16]), .i_or_d(obs1[15]),
      .ir_write(obs1[14]), .mem_to_reg(obs1[13]), .reg_write(obs1[12]),
      .pc_to_reg(obs1[11]), .pc_write(obs1[10]), .alu_src_a(obs1[9]),
      .is_ecall(obs1[8]), .illegal_inst(obs1[7]), .halted(obs1[6]),
      .alu_src_b(obs1[5:4]), .alu_op(obs1[3:2]), .pc_source(obs1[1:0])
   );

   // {alu_src_b, alu_op, pc_source} field helper
   function automatic logic [17:0] fld(input logic [1:0] b, input logic [1:0] a, input logic [1:0] p);
      return {12'b0, b, a, p};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return (op == LOAD) || (op == STORE) || (op == ARITH) || (op == ARIMM) ||
             (op == BRAN) || (op == JAL) || (op == JALR) || (op == ECALL);
   endfunction

   function automatic logic [6:0] pick_op();
      logic [6:0] op;
      case ($urandom_range(0, 8))
         0: op = LOAD;
         1: op = STORE;
         2: op = ARITH;
         3: op = ARIMM;
         4: op = BRAN;
         5: op = JAL;
         6: op = JALR;
         7: op = ECALL;
         default: begin
            op = 7'($urandom);
            while (is_legal(op)) op = 7'($urandom);
         end
      endcase
      return op;
   endfunction

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   // Expected per-cycle control word sequence for one instruction.
   task automatic build(input logic [6:0] op, input logic b, input logic h, input int w);
      logic [17:0] id;
      id = fld(2'd1, 2'd0, 2'd0);
      expq.delete();
      for (int i = 0; i <= w; i++) expq.push_back(MR | ((i == w) ? IRW : 18'h0));
      case (op)
         LOAD, STORE: begin
            expq.push_back(id);
            expq.push_back(ASA | fld(2'd2, 2'd0, 2'd0));
            for (int i = 0; i <= w; i++)
               expq.push_back(IOD | ((op == LOAD) ? MR : MW) |
                              ((op == STORE && i == w) ? PW : 18'h0));
            if (op == LOAD) expq.push_back(RW | PW | M2R);
         end
         ARITH: begin
            expq.push_back(id);
            expq.push_back(ASA | fld(2'd0, 2'd2, 2'd0));
            expq.push_back(RW | PW);
         end
         ARIMM: begin
            expq.push_back(id);
            expq.push_back(ASA | fld(2'd2, 2'd2, 2'd0));
            expq.push_back(RW | PW);
         end
         BRAN: begin
            expq.push_back(id);
            expq.push_back(PW | fld(2'd0, 2'd1, b ? 2'd1 : 2'd0));
         end
         JAL: begin
            expq.push_back(id);
            expq.push_back(fld(2'd2, 2'd0, 2'd0));
            expq.push_back(RW | PW | P2R | fld(2'd0, 2'd0, 2'd1));
         end
         JALR: begin
            expq.push_back(id);
            expq.push_back(ASA | fld(2'd2, 2'd0, 2'd0));
            expq.push_back(RW | PW | P2R | fld(2'd0, 2'd0, 2'd2));
         end
         ECALL: begin
            if (HALT_EN && h) begin
               expq.push_back(id | EC);
               for (int i = 0; i < 20; i++) expq.push_back(HLT);
            end else begin
               expq.push_back(id | EC | PW);
            end
         end
         default: expq.push_back(id | ILL | PW);
      endcase
   endtask

   // Runs one instruction on DUT k (0: MEM_WAIT=0, 1: MEM_WAIT=2), checking
   // every cycle; stop_at >= 0 truncates after that cycle index.
   task automatic run(input int k, input logic [6:0] op, input logic b, input logic h,
                      input int stop_at, input string tag);
      int w;
      int n;
      w = (k != 0) ? 2 : 0;
      build(op, b, h, w);
      n = (stop_at < 0) ? expq.size() : stop_at + 1;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         opc = (j <= w + 1) ? op : 7'($urandom);
         bc  = (j == w + 2) ? b  : 1'($urandom);
         hr  = (j == w + 1) ? h  : 1'($urandom);
         #1;
         check($sformatf("%s_k%0d_op%b_c%0d", tag, k, op, j), (k != 0) ? obs1 : obs0, expq[j]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_async_u0", obs0, MR);
      check("rst_async_u1", obs1, MR);
      @(posedge clk);
      #1;
      check("rst_held_u0", obs0, MR);
      check("rst_held_u1", obs1, MR);
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      opc   = '0;
      bc    = 1'b0;
      hr    = 1'b0;
      do_reset();

      // MEM_WAIT = 0
      run(0, ARITH, 1'b0, 1'b0, -1, "add");
      run(0, BRAN,  1'b1, 1'b0, -1, "beq_t");
      run(0, BRAN,  1'b0, 1'b0, -1, "beq_nt");
      run(0, ECALL, 1'b0, 1'b0, -1, "ecall0");
      run(0, 7'h00, 1'b0, 1'b0, -1, "ill0");
      run(0, LOAD,  1'b0, 1'b0, -1, "lw0");
      run(0, STORE, 1'b0, 1'b0, -1, "sw0");
      for (int i = 0; i < 40; i++) run(0, pick_op(), 1'($urandom), 1'b0, -1, "rnd0");

      // MEM_WAIT = 2
      do_reset();
      run(1, LOAD,  1'b0, 1'b0, -1, "lw2");
      run(1, STORE, 1'b0, 1'b0, -1, "sw2");
      run(1, JALR,  1'b0, 1'b0, -1, "jalr2");
      for (int i = 0; i < 30; i++) run(1, pick_op(), 1'($urandom), 1'b0, -1, "rnd2");

      // Reset in the middle of a store's MEM phase (cycle index 6 = MEM wait 1)
      run(1, STORE, 1'b0, 1'b0, 6, "sw_cut");
      #2 reset = 1'b0;
      #1;
      check("sw_cut_rst_word", obs1, MR);
      check("sw_cut_rst_mw", {17'b0, obs1[16]}, 18'h0);
      @(posedge clk);
      #1;
      check("sw_cut_rst_edge", obs1, MR);
      @(posedge clk);
      #2 reset = 1'b1;
      run(1, 7'h00, 1'b0, 1'b0, -1, "ill_after_rst");

      // ECALL with halt request on both DUTs
      do_reset();
      run(0, ECALL, 1'b0, 1'b1, -1, "ecall_h0");
      if (!HALT_EN) run(0, ARITH, 1'b0, 1'b0, -1, "after_ecall_h0");
      do_reset();
      run(1, ECALL, 1'b0, 1'b1, -1, "ecall_h2");
      do_reset();
      run(1, ARITH, 1'b0, 1'b0, -1, "after_halt_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
